// File: rtl/demux_scan_ctrl_pkg.sv
// Shared types and constants for the LED demux scan scheduler.
// Channel count is fixed at 16, so the select is always 4 bits wide.
package demux_scan_ctrl_pkg;

    localparam int NCH  = 16;
    localparam int SELW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // The encoding 3 behaves exactly like MODE_LOOP.
    // The mode is normalised to MODE_LOOP when it is latched.
    typedef enum logic [1:0] {
        MODE_LOOP = 2'd0,
        MODE_ONCE = 2'd1,
        MODE_PING = 2'd2,
        MODE_ALT  = 2'd3
    } mode_t;

endpackage

// File: rtl/demux_next_sel.sv
// Finds the next enabled channel from cur in the given direction, modulo 16.
// With wrap=0, found is low when no enabled channel lies ahead before the edge of the range.
module demux_next_sel
    import demux_scan_ctrl_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] cur,
    input  logic            dir_down,
    input  logic            wrap,
    output logic [SELW-1:0] nxt,
    output logic            found
);

    localparam int PW = SELW + 1;

    // The loop runs from the farthest candidate to the nearest, so the nearest hit wins.
    // Distance 16 lands back on cur, which lets a lone enabled channel be found while wrapping.
    always_comb begin
        logic [PW-1:0]   pos;
        logic            crossed;
        logic [SELW-1:0] idx;
        nxt     = cur;
        found   = 1'b0;
        pos     = '0;
        crossed = 1'b0;
        idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (dir_down) begin
                pos     = {1'b0, cur} - PW'(k);
                crossed = ({1'b0, cur} < PW'(k));
            end else begin
                pos     = {1'b0, cur} + PW'(k);
                crossed = pos[SELW];
            end
            idx = pos[SELW-1:0];
            if (mask[idx] && (wrap || !crossed)) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan scheduler for the 1-to-16 LED demux: it dwells DIV clocks on each channel that the mask enables.
// Loop, single-pass and ping-pong orders are supported. All outputs are registered.
module demux_scan_ctrl
    import demux_scan_ctrl_pkg::*;
#(
    parameter int DIV = 25000000
) (
    input  logic            CLOCK_50,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic            dir_down,
    input  logic [NCH-1:0]  mask,
    output logic [SELW-1:0] sel,
    output logic            en,
    output logic            busy,
    output logic            done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t          state, state_n;
    mode_t           mode_q, mode_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            dir, dir_n;
    logic [SELW-1:0] sel_n;
    logic            en_n, busy_n, done_n;

    logic [SELW-1:0] fwd_cur, fwd_nxt, rev_nxt;
    logic            fwd_dir, fwd_wrap, fwd_found, rev_found;
    logic            go, abort, dwell_end, once_end;

    // In IDLE the forward search is seeded one step before the first channel, with wrap enabled.
    // An ascending search from 15 therefore returns the lowest enabled bit.
    // A descending search from 0 returns the highest enabled bit.
    assign fwd_cur  = (state == IDLE) ? (dir_down ? '0 : '1) : sel;
    assign fwd_dir  = (state == IDLE) ? dir_down : dir;
    assign fwd_wrap = (state == IDLE) || (mode_q == MODE_LOOP);

    demux_next_sel u_fwd (
        .mask     (mask),
        .cur      (fwd_cur),
        .dir_down (fwd_dir),
        .wrap     (fwd_wrap),
        .nxt      (fwd_nxt),
        .found    (fwd_found)
    );

    demux_next_sel u_rev (
        .mask     (mask),
        .cur      (sel),
        .dir_down (~dir),
        .wrap     (1'b0),
        .nxt      (rev_nxt),
        .found    (rev_found)
    );

    assign go        = start && !stop && (|mask);
    assign abort     = stop || !(|mask);
    assign dwell_end = (cnt == CW'(DIV - 1));
    assign once_end  = dwell_end && (mode_q == MODE_ONCE) && !fwd_found;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= MODE_LOOP;
            cnt    <= '0;
            dir    <= 1'b0;
            sel    <= '0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            cnt    <= cnt_n;
            dir    <= dir_n;
            sel    <= sel_n;
            en     <= en_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go) state_n = SCAN;
            SCAN:    if (abort || once_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // en follows the live mask bit of the held channel, so a channel masked out mid-dwell goes dark at once.
    always_comb begin
        mode_n = mode_q;
        cnt_n  = cnt;
        dir_n  = dir;
        sel_n  = sel;
        en_n   = en;
        busy_n = busy;
        done_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                sel_n  = '0;
                en_n   = 1'b0;
                busy_n = 1'b0;
                if (go) begin
                    sel_n  = fwd_nxt;
                    en_n   = 1'b1;
                    busy_n = 1'b1;
                    dir_n  = dir_down;
                    case (mode)
                        2'd1:    mode_n = MODE_ONCE;
                        2'd2:    mode_n = MODE_PING;
                        default: mode_n = MODE_LOOP;
                    endcase
                end
            end
            SCAN: begin
                if (abort || once_end) begin
                    cnt_n  = '0;
                    sel_n  = '0;
                    en_n   = 1'b0;
                    busy_n = 1'b0;
                    done_n = once_end && !abort;
                end else if (dwell_end) begin
                    cnt_n = '0;
                    if (fwd_found) begin
                        sel_n = fwd_nxt;
                    end else if (mode_q == MODE_PING && rev_found) begin
                        sel_n = rev_nxt;
                        dir_n = ~dir;
                    end
                    en_n   = mask[sel_n];
                    busy_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                    en_n  = mask[sel];
                end
            end
            default: begin
                sel_n  = '0;
                en_n   = 1'b0;
                busy_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl. Instance dut4 uses DIV=4 and instance dut3 uses DIV=3.
// Both instances share every input and are reset at the start of each scenario.
module tb_demux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic        dir_down;
    logic [15:0] mask;

    logic [3:0]  sel4, sel3;
    logic        en4, busy4, done4;
    logic        en3, busy3, done3;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_scan_ctrl #(.DIV(4)) dut4 (
        .CLOCK_50 (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir_down (dir_down),
        .mask     (mask),
        .sel      (sel4),
        .en       (en4),
        .busy     (busy4),
        .done     (done4)
    );

    demux_scan_ctrl #(.DIV(3)) dut3 (
        .CLOCK_50 (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir_down (dir_down),
        .mask     (mask),
        .sel      (sel3),
        .en       (en3),
        .busy     (busy3),
        .done     (done3)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; dir_down = 1'b0; mask = 16'h0000;
        tick();
        tick();
        if ({sel4, en4, busy4, done4} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut4: got sel=%0d en=%b busy=%b done=%b, want all 0", sel4, en4, busy4, done4);
        end
        vectors++;
        if ({sel3, en3, busy3, done3} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut3: got sel=%0d en=%b busy=%b done=%b, want all 0", sel3, en3, busy3, done3);
        end
        vectors++;
        rst = 1'b0;
    endtask

    task automatic test_loop();
        logic [3:0] exp_sel;
        do_reset();
        mask = 16'hFFFF; mode = 2'd0; dir_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int ch = 0; ch <= 16; ch++) begin
            for (int d = 0; d < 4; d++) begin
                exp_sel = 4'(ch % 16);
                if (sel4 !== exp_sel || en4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL loop step %0d.%0d: got sel=%0d en=%b busy=%b done=%b, want sel=%0d en=1 busy=1 done=0",
                             ch, d, sel4, en4, busy4, done4, exp_sel);
                end
                vectors++;
                tick();
            end
        end
    endtask

    task automatic test_mode3();
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        do_reset();
        mask = 16'h0007; mode = 2'd3; dir_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sel4 !== seq[i] || en4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL mode3 step %0d.%0d: got sel=%0d en=%b busy=%b done=%b, want sel=%0d en=1 busy=1 done=0",
                             i, d, sel4, en4, busy4, done4, seq[i]);
                end
                vectors++;
                tick();
            end
        end
    endtask

    task automatic test_once();
        logic [3:0] seq [4];
        seq = '{4'd15, 4'd10, 4'd5, 4'd0};
        do_reset();
        mask = 16'h8421; mode = 2'd1; dir_down = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sel4 !== seq[i] || en4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL once step %0d.%0d: got sel=%0d en=%b busy=%b done=%b, want sel=%0d en=1 busy=1 done=0",
                             i, d, sel4, en4, busy4, done4, seq[i]);
                end
                vectors++;
                tick();
            end
        end
        if (sel4 !== 4'd0 || en4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL once_done: got sel=%0d en=%b busy=%b done=%b, want sel=0 en=0 busy=0 done=1",
                     sel4, en4, busy4, done4);
        end
        vectors++;
        tick();
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL once_after: got busy=%b done=%b, want busy=0 done=0", busy4, done4);
        end
        vectors++;
    endtask

    task automatic test_ping();
        logic [3:0] seq [7];
        seq = '{4'd0, 4'd1, 4'd4, 4'd1, 4'd0, 4'd1, 4'd4};
        do_reset();
        mask = 16'h0013; mode = 2'd2; dir_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (sel3 !== seq[i] || en3 !== 1'b1 || busy3 !== 1'b1 || done3 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL ping step %0d.%0d: got sel=%0d en=%b busy=%b done=%b, want sel=%0d en=1 busy=1 done=0",
                             i, d, sel3, en3, busy3, done3, seq[i]);
                end
                vectors++;
                tick();
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        mask = 16'h0040; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sel3 !== 4'd6 || en3 !== 1'b1 || busy3 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL ping_single %0d: got sel=%0d en=%b busy=%b, want sel=6 en=1 busy=1",
                         i, sel3, en3, busy3);
            end
            vectors++;
            tick();
        end
    endtask

    task automatic test_live_mask();
        do_reset();
        mask = 16'h00FF; mode = 2'd0; dir_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        if (sel4 !== 4'd2 || en4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL live_reach2: got sel=%0d en=%b, want sel=2 en=1", sel4, en4);
        end
        vectors++;
        mask = 16'h00FB;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sel4 !== 4'd2 || en4 !== 1'b0 || busy4 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL live_masked %0d: got sel=%0d en=%b busy=%b, want sel=2 en=0 busy=1",
                         i, sel4, en4, busy4);
            end
            vectors++;
        end
        tick();
        if (sel4 !== 4'd3 || en4 !== 1'b1 || busy4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL live_advance: got sel=%0d en=%b busy=%b, want sel=3 en=1 busy=1", sel4, en4, busy4);
        end
        vectors++;
        mask = 16'h0000;
        tick();
        if (sel4 !== 4'd0 || en4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL live_mask0: got sel=%0d en=%b busy=%b done=%b, want all 0", sel4, en4, busy4, done4);
        end
        vectors++;
    endtask

    task automatic test_stop();
        do_reset();
        mask = 16'hFFFF; mode = 2'd1; dir_down = 1'b0;
        start = 1'b1; stop = 1'b1;
        tick();
        tick();
        if (busy4 !== 1'b0 || en4 !== 1'b0 || sel4 !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL start_stop_idle: got sel=%0d en=%b busy=%b, want sel=0 en=0 busy=0", sel4, en4, busy4);
        end
        vectors++;
        stop = 1'b0;
        tick();
        start = 1'b0;
        if (busy4 !== 1'b1 || sel4 !== 4'd0 || en4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stop_started: got sel=%0d en=%b busy=%b, want sel=0 en=1 busy=1", sel4, en4, busy4);
        end
        vectors++;
        tick();
        tick();
        stop = 1'b1;
        tick();
        if ({sel4, en4, busy4, done4} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_midscan: got sel=%0d en=%b busy=%b done=%b, want all 0", sel4, en4, busy4, done4);
        end
        vectors++;
        tick();
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_nodone: got busy=%b done=%b, want busy=0 done=0", busy4, done4);
        end
        vectors++;
        stop = 1'b0;
        mask = 16'h0000; start = 1'b1;
        tick();
        tick();
        if (busy4 !== 1'b0 || en4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_mask0: got busy=%b en=%b, want busy=0 en=0", busy4, en4);
        end
        vectors++;
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_sel;
        do_reset();
        mask = 16'hFFFF; mode = 2'd0; dir_down = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        // Descending from 15: channel 9 first appears after 6 full dwells, then one extra cycle lands mid-dwell.
        for (int i = 0; i < 25; i++) tick();
        if (sel4 !== 4'd9 || busy4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_reach9: got sel=%0d busy=%b, want sel=9 busy=1", sel4, busy4);
        end
        vectors++;
        rst = 1'b1;
        tick();
        if ({sel4, en4, busy4, done4} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_clear: got sel=%0d en=%b busy=%b done=%b, want all 0", sel4, en4, busy4, done4);
        end
        vectors++;
        rst = 1'b0;
        tick();
        mask = 16'h0300; dir_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_sel = (i < 4) ? 4'd8 : 4'd9;
            if (sel4 !== exp_sel || en4 !== 1'b1 || busy4 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rstmid_resume %0d: got sel=%0d en=%b busy=%b, want sel=%0d en=1 busy=1",
                         i, sel4, en4, busy4, exp_sel);
            end
            vectors++;
            tick();
        end
    endtask

    initial begin
        $display("[TB] demux_scan_ctrl directed bench start");
        test_reset();
        test_loop();
        test_mode3();
        test_once();
        test_ping();
        test_live_mask();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
